// File: rtl/lt24_pixel_writer.sv
// rtl/lt24_pixel_writer.sv - LT24 panel init sequencer and single-pixel 8080 bus writer (optional LT24_AUTOINC_EN)
module lt24_pixel_writer #(
    parameter int RST_CYCLES   = 4000,
    parameter int SLEEP_CYCLES = 6000000,
    parameter int WR_HALF      = 1
) (
    input  logic        clock,
    input  logic        globalReset,
    output logic        resetApp,
    input  logic [7:0]  xAddr,
    input  logic [8:0]  yAddr,
    input  logic [15:0] pixelData,
    input  logic        pixelWrite,
    output logic        pixelReady,
    output logic        LT24Wr_n,
    output logic        LT24Rd_n,
    output logic        LT24CS_n,
    output logic        LT24RS,
    output logic        LT24Reset_n,
    output logic        LT24LCDOn,
    output logic [15:0] LT24Data
);

    localparam logic [31:0] RST_LAST   = 32'(RST_CYCLES - 1);
    localparam logic [31:0] SLEEP_LAST = 32'(SLEEP_CYCLES - 1);
    localparam logic [31:0] HALF_LAST  = 32'(WR_HALF - 1);
    localparam logic [3:0]  PIX_WORD   = 4'd11;

    typedef enum logic [2:0] {
        ST_RST_LO, ST_RST_WAIT, ST_SLPOUT, ST_SLP_WAIT,
        ST_DISPON, ST_IDLE, ST_XFER, ST_DROP
    } state_t;

    // SETUP is the single clock between entering a bus state and the first Wr_n fall
    typedef enum logic [1:0] {PH_SETUP, PH_LOW, PH_HIGH} phase_t;

    state_t      state_q, state_d;
    phase_t      phase_q, phase_d;
    logic [31:0] cnt_q, cnt_d;
    logic [3:0]  word_q, word_d;
    logic        wr_n_q, wr_n_d;
    logic        rs_q, rs_d;
    logic [15:0] data_q, data_d;
    logic        reset_n_q, reset_n_d;
    logic        cs_n_q, cs_n_d;
    logic        lcd_on_q, lcd_on_d;
    logic        reset_app_q, reset_app_d;
    logic [7:0]  x_q, x_d;
    logic [8:0]  y_q, y_d;
    logic [15:0] pix_q, pix_d;

    logic        in_range;
    logic        is_cont;
    logic [3:0]  sel_idx;
    logic [16:0] bus_word;
    logic        word_last;
    logic        bus_done;

`ifdef LT24_AUTOINC_EN
    logic [7:0]  last_x_q, last_x_d;
    logic [8:0]  last_y_q, last_y_d;
    logic        cont_valid_q, cont_valid_d;

    assign is_cont = cont_valid_q && (yAddr == last_y_q)
                     && ({1'b0, xAddr} == ({1'b0, last_x_q} + 9'd1));
`else
    assign is_cont = 1'b0;
`endif

    assign in_range    = (xAddr <= 8'd239) && (yAddr <= 9'd319);
    assign pixelReady  = (state_q == ST_IDLE);
    assign resetApp    = reset_app_q;
    assign LT24Wr_n    = wr_n_q;
    assign LT24Rd_n    = 1'b1;
    assign LT24CS_n    = cs_n_q;
    assign LT24RS      = rs_q;
    assign LT24Reset_n = reset_n_q;
    assign LT24LCDOn   = lcd_on_q;
    assign LT24Data    = data_q;

    // {rs, data} for each of the 12 words of a full pixel write
    function automatic logic [16:0] xfer_word(input logic [3:0] idx, input logic [7:0] x,
                                              input logic [8:0] y, input logic [15:0] pix);
        case (idx)
            4'd0:    xfer_word = {1'b0, 16'h002A};
            4'd1:    xfer_word = {1'b1, 16'h0000};
            4'd2:    xfer_word = {1'b1, 8'h00, x};
            4'd3:    xfer_word = {1'b1, 16'h0000};
            4'd4:    xfer_word = {1'b1, 16'h00EF};
            4'd5:    xfer_word = {1'b0, 16'h002B};
            4'd6:    xfer_word = {1'b1, 15'h0000, y[8]};
            4'd7:    xfer_word = {1'b1, 8'h00, y[7:0]};
            4'd8:    xfer_word = {1'b1, 16'h0001};
            4'd9:    xfer_word = {1'b1, 16'h003F};
            4'd10:   xfer_word = {1'b0, 16'h002C};
            default: xfer_word = {1'b1, pix};
        endcase
    endfunction

    // Word source: fixed init commands, or the pixel table (looking one word ahead at the end of a high phase)
    always_comb begin
        sel_idx   = (phase_q == PH_HIGH) ? (word_q + 4'd1) : word_q;
        bus_word  = xfer_word(sel_idx, x_q, y_q, pix_q);
        word_last = (word_q == PIX_WORD);
        if (state_q == ST_SLPOUT) begin
            bus_word  = {1'b0, 16'h0011};
            word_last = 1'b1;
        end else if (state_q == ST_DISPON) begin
            bus_word  = {1'b0, 16'h0029};
            word_last = 1'b1;
        end
    end

    // Next-state logic: init sequence, handshake, and the shared Wr_n word engine
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        cnt_d       = cnt_q;
        word_d      = word_q;
        wr_n_d      = wr_n_q;
        rs_d        = rs_q;
        data_d      = data_q;
        reset_n_d   = reset_n_q;
        cs_n_d      = cs_n_q;
        lcd_on_d    = lcd_on_q;
        reset_app_d = reset_app_q;
        x_d         = x_q;
        y_d         = y_q;
        pix_d       = pix_q;
        bus_done    = 1'b0;
`ifdef LT24_AUTOINC_EN
        last_x_d     = last_x_q;
        last_y_d     = last_y_q;
        cont_valid_d = cont_valid_q;
`endif

        if (state_q inside {ST_SLPOUT, ST_DISPON, ST_XFER}) begin
            case (phase_q)
                PH_SETUP: begin
                    wr_n_d         = 1'b0;
                    {rs_d, data_d} = bus_word;
                    phase_d        = PH_LOW;
                    cnt_d          = 32'd0;
                end
                PH_LOW: begin
                    if (cnt_q == HALF_LAST) begin
                        wr_n_d  = 1'b1;
                        phase_d = PH_HIGH;
                        cnt_d   = 32'd0;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
                PH_HIGH: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_d = 32'd0;
                        if (word_last) begin
                            bus_done = 1'b1;
                        end else begin
                            word_d         = word_q + 4'd1;
                            wr_n_d         = 1'b0;
                            {rs_d, data_d} = bus_word;
                            phase_d        = PH_LOW;
                        end
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
                default: phase_d = PH_SETUP;
            endcase
        end

        case (state_q)
            ST_RST_LO: begin
                if (cnt_q == RST_LAST) begin
                    state_d   = ST_RST_WAIT;
                    cnt_d     = 32'd0;
                    reset_n_d = 1'b1;
                    cs_n_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ST_RST_WAIT: begin
                if (cnt_q == RST_LAST) begin
                    state_d = ST_SLPOUT;
                    cnt_d   = 32'd0;
                    phase_d = PH_SETUP;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ST_SLPOUT: begin
                if (bus_done) state_d = ST_SLP_WAIT;
            end
            ST_SLP_WAIT: begin
                if (cnt_q == SLEEP_LAST) begin
                    state_d = ST_DISPON;
                    cnt_d   = 32'd0;
                    phase_d = PH_SETUP;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ST_DISPON: begin
                if (bus_done) begin
                    state_d     = ST_IDLE;
                    lcd_on_d    = 1'b1;
                    reset_app_d = 1'b0;
                end
            end
            ST_IDLE: begin
                if (pixelWrite) begin
                    x_d   = xAddr;
                    y_d   = yAddr;
                    pix_d = pixelData;
                    if (!in_range) begin
                        state_d = ST_DROP;
`ifdef LT24_AUTOINC_EN
                        cont_valid_d = 1'b0;
`endif
                    end else begin
                        state_d = ST_XFER;
                        phase_d = PH_SETUP;
                        cnt_d   = 32'd0;
                        word_d  = is_cont ? PIX_WORD : 4'd0;
                    end
                end
            end
            ST_XFER: begin
                if (bus_done) begin
                    state_d = ST_IDLE;
`ifdef LT24_AUTOINC_EN
                    last_x_d     = x_q;
                    last_y_d     = y_q;
                    cont_valid_d = 1'b1;
`endif
                end
            end
            ST_DROP: state_d = ST_IDLE;
            default: state_d = ST_RST_LO;
        endcase
    end

    // State and output registers; reset drops everything back to panel-reset values at once
    always_ff @(posedge clock or posedge globalReset) begin
        if (globalReset) begin
            state_q     <= ST_RST_LO;
            phase_q     <= PH_SETUP;
            cnt_q       <= 32'd0;
            word_q      <= 4'd0;
            wr_n_q      <= 1'b1;
            rs_q        <= 1'b1;
            data_q      <= 16'h0000;
            reset_n_q   <= 1'b0;
            cs_n_q      <= 1'b1;
            lcd_on_q    <= 1'b0;
            reset_app_q <= 1'b1;
            x_q         <= 8'd0;
            y_q         <= 9'd0;
            pix_q       <= 16'h0000;
`ifdef LT24_AUTOINC_EN
            last_x_q     <= 8'd0;
            last_y_q     <= 9'd0;
            cont_valid_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            cnt_q       <= cnt_d;
            word_q      <= word_d;
            wr_n_q      <= wr_n_d;
            rs_q        <= rs_d;
            data_q      <= data_d;
            reset_n_q   <= reset_n_d;
            cs_n_q      <= cs_n_d;
            lcd_on_q    <= lcd_on_d;
            reset_app_q <= reset_app_d;
            x_q         <= x_d;
            y_q         <= y_d;
            pix_q       <= pix_d;
`ifdef LT24_AUTOINC_EN
            last_x_q     <= last_x_d;
            last_y_q     <= last_y_d;
            cont_valid_q <= cont_valid_d;
`endif
        end
    end

endmodule

// File: tb/tb_lt24_pixel_writer.sv
// tb/tb_lt24_pixel_writer.sv - self-checking bench for lt24_pixel_writer
module tb_lt24_pixel_writer;

    localparam int RST_CYCLES   = 4;
    localparam int SLEEP_CYCLES = 8;
    localparam int WR_HALF      = 1;
    localparam int FULL_BUSY    = 24 * WR_HALF + 1;
`ifdef LT24_AUTOINC_EN
    localparam int CONT_BUSY    = 2 * WR_HALF + 1;
`else
    localparam int CONT_BUSY    = 24 * WR_HALF + 1;
`endif

    logic        clock = 1'b0;
    logic        globalReset = 1'b0;
    logic        resetApp;
    logic [7:0]  xAddr = '0;
    logic [8:0]  yAddr = '0;
    logic [15:0] pixelData = '0;
    logic        pixelWrite = 1'b0;
    logic        pixelReady;
    logic        LT24Wr_n, LT24Rd_n, LT24CS_n, LT24RS, LT24Reset_n, LT24LCDOn;
    logic [15:0] LT24Data;

    always #5 clock = ~clock;

    lt24_pixel_writer #(
        .RST_CYCLES(RST_CYCLES), .SLEEP_CYCLES(SLEEP_CYCLES), .WR_HALF(WR_HALF)
    ) dut (
        .clock(clock), .globalReset(globalReset), .resetApp(resetApp),
        .xAddr(xAddr), .yAddr(yAddr), .pixelData(pixelData),
        .pixelWrite(pixelWrite), .pixelReady(pixelReady),
        .LT24Wr_n(LT24Wr_n), .LT24Rd_n(LT24Rd_n), .LT24CS_n(LT24CS_n),
        .LT24RS(LT24RS), .LT24Reset_n(LT24Reset_n), .LT24LCDOn(LT24LCDOn),
        .LT24Data(LT24Data)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Bus monitor: one entry {rs, data} per Wr_n falling edge, plus pulse-width and stability tracking
    logic [16:0] got_q[$];
    logic        prev_wr = 1'b1;
    logic        in_word = 1'b0;
    logic [16:0] cur_word = '0;
    int          lo_cnt = 0, hi_cnt = 0;
    int          bad_width = 0, bad_stable = 0;

    always @(negedge clock) begin
        if (globalReset) begin
            prev_wr = 1'b1;
            in_word = 1'b0;
        end else begin
            if (prev_wr && !LT24Wr_n) begin
                got_q.push_back({LT24RS, LT24Data});
                cur_word = {LT24RS, LT24Data};
                in_word  = 1'b1;
                lo_cnt   = 0;
                hi_cnt   = 0;
            end
            if (in_word) begin
                if ({LT24RS, LT24Data} !== cur_word) bad_stable++;
                if (!LT24Wr_n) lo_cnt++;
                else begin
                    if (hi_cnt == 0 && lo_cnt != WR_HALF) bad_width++;
                    hi_cnt++;
                    if (hi_cnt == WR_HALF) in_word = 1'b0;
                end
            end
            prev_wr = LT24Wr_n;
        end
    end

    // Reference model: the word list and busy time each request should produce
    logic [16:0] exp_q[$];
`ifdef LT24_AUTOINC_EN
    int m_last_x = 0, m_last_y = 0;
    bit m_cont = 0;
`endif

    task automatic model_pixel(input int x, input int y, input logic [15:0] d, output int busy);
        logic [15:0] xv, yv;
        if (x > 239 || y > 319) begin
`ifdef LT24_AUTOINC_EN
            m_cont = 0;
`endif
            busy = 1;
            return;
        end
`ifdef LT24_AUTOINC_EN
        if (m_cont && y == m_last_y && x == m_last_x + 1) begin
            exp_q.push_back({1'b1, d});
            m_last_x = x;
            busy = 2 * WR_HALF + 1;
            return;
        end
        m_last_x = x;
        m_last_y = y;
        m_cont   = 1;
`endif
        xv = 16'(x);
        yv = 16'(y);
        exp_q.push_back({1'b0, 16'h002A});
        exp_q.push_back({1'b1, 16'h0000});
        exp_q.push_back({1'b1, xv});
        exp_q.push_back({1'b1, 16'h0000});
        exp_q.push_back({1'b1, 16'd239});
        exp_q.push_back({1'b0, 16'h002B});
        exp_q.push_back({1'b1, yv / 16'd256});
        exp_q.push_back({1'b1, yv % 16'd256});
        exp_q.push_back({1'b1, 16'h0001});
        exp_q.push_back({1'b1, 16'd63});
        exp_q.push_back({1'b0, 16'h002C});
        exp_q.push_back({1'b1, d});
        busy = 24 * WR_HALF + 1;
    endtask

    task automatic model_reset();
`ifdef LT24_AUTOINC_EN
        m_cont = 0;
`endif
    endtask

    task automatic compare_stream(input string name);
        check({name, " word count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s word %0d", name, i), 32'(got_q[i]), 32'(exp_q[i]));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " resetApp"},    resetApp,    1'b1);
        check({tag, " pixelReady"},  pixelReady,  1'b0);
        check({tag, " LT24Reset_n"}, LT24Reset_n, 1'b0);
        check({tag, " LT24CS_n"},    LT24CS_n,    1'b1);
        check({tag, " LT24Wr_n"},    LT24Wr_n,    1'b1);
        check({tag, " LT24Rd_n"},    LT24Rd_n,    1'b1);
        check({tag, " LT24RS"},      LT24RS,      1'b1);
        check({tag, " LT24Data"},    LT24Data,    16'h0000);
        check({tag, " LT24LCDOn"},   LT24LCDOn,   1'b0);
    endtask

    // Release reset at a falling edge and follow the init sequence through to IDLE
    task automatic release_and_init(input string tag);
        int lo, total;
        @(negedge clock);
        got_q.delete();
        globalReset = 1'b0;
        check({tag, " resetApp held during init"}, resetApp, 1'b1);
        lo = 0;
        while (LT24Reset_n === 1'b0 && lo < 100) begin
            lo++;
            @(negedge clock);
        end
        check({tag, " Reset_n low clocks"}, lo, RST_CYCLES);
        check({tag, " CS_n low after release"}, LT24CS_n, 1'b0);
        total = lo;
        while (pixelReady !== 1'b1 && total < 500) begin
            total++;
            @(negedge clock);
        end
        check({tag, " init length in range"},
              (total >= 2*RST_CYCLES + SLEEP_CYCLES + 4*WR_HALF) &&
              (total <= 2*RST_CYCLES + SLEEP_CYCLES + 4*WR_HALF + 8), 1);
        check({tag, " init word count"}, got_q.size(), 2);
        if (got_q.size() == 2) begin
            check({tag, " SLPOUT word"}, 32'(got_q[0]), {15'd0, 1'b0, 16'h0011});
            check({tag, " DISPON word"}, 32'(got_q[1]), {15'd0, 1'b0, 16'h0029});
        end
        check({tag, " LCDOn"},    LT24LCDOn, 1'b1);
        check({tag, " resetApp"}, resetApp,  1'b0);
        check({tag, " pixelReady"}, pixelReady, 1'b1);
        model_reset();
    endtask

    // One pulsed request from a falling edge; returns busy clocks and the Wr_n level 1 and 2 clocks after acceptance
    task automatic send_pixel(input int x, input int y, input logic [15:0] d,
                              output int busy, output logic s0, output logic s1);
        int guard = 0;
        while (pixelReady !== 1'b1 && guard < 1000) begin
            guard++;
            @(negedge clock);
        end
        check("ready before request", pixelReady, 1'b1);
        xAddr = 8'(x);
        yAddr = 9'(y);
        pixelData  = d;
        pixelWrite = 1'b1;
        @(negedge clock);
        pixelWrite = 1'b0;
        xAddr = 8'(~x);
        pixelData = ~d;
        s0 = LT24Wr_n;
        s1 = 1'b1;
        busy = 0;
        while (pixelReady !== 1'b1 && busy < 1000) begin
            busy++;
            @(negedge clock);
            if (busy == 1) s1 = LT24Wr_n;
        end
    endtask

    typedef struct {
        int          x;
        int          y;
        logic [15:0] d;
        int          busy;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int busy, mbusy, x, y, px, py, sel, guard;
        logic s0, s1;

        vecs[0]  = '{5,   300, 16'hF800, FULL_BUSY};
        vecs[1]  = '{10,  20,  16'h07E0, FULL_BUSY};
        vecs[2]  = '{11,  20,  16'h001F, CONT_BUSY};
        vecs[3]  = '{239, 20,  16'hFFFF, FULL_BUSY};
        vecs[4]  = '{0,   21,  16'h1234, FULL_BUSY};
        vecs[5]  = '{50,  7,   16'hABCD, FULL_BUSY};
        vecs[6]  = '{240, 7,   16'h5555, 1};
        vecs[7]  = '{51,  7,   16'hAAAA, FULL_BUSY};
        vecs[8]  = '{52,  7,   16'h0F0F, CONT_BUSY};
        vecs[9]  = '{100, 320, 16'h0000, 1};
        vecs[10] = '{239, 319, 16'h8001, FULL_BUSY};
        vecs[11] = '{0,   0,   16'h0000, FULL_BUSY};

        #1 globalReset = 1'b1;
        #2;
        check_reset_values("reset");
        repeat (3) @(negedge clock);
        check_reset_values("reset held");
        release_and_init("init");

        for (int i = 0; i < 12; i++) begin
            got_q.delete();
            exp_q.delete();
            model_pixel(vecs[i].x, vecs[i].y, vecs[i].d, mbusy);
            send_pixel(vecs[i].x, vecs[i].y, vecs[i].d, busy, s0, s1);
            check($sformatf("vec%0d busy clocks", i), busy, vecs[i].busy);
            check($sformatf("vec%0d model busy", i), busy, mbusy);
            check($sformatf("vec%0d Wr_n after accept", i), {s0, s1}, {1'b1, vecs[i].busy == 1});
            compare_stream($sformatf("vec%0d", i));
        end

        got_q.delete();
        exp_q.delete();
        x = $urandom_range(150, 239);
        y = $urandom_range(0, 300);
        pixelWrite = 1'b1;
        for (int i = 0; i < 100; i++) begin
            xAddr = 8'(x);
            yAddr = 9'(y);
            pixelData = 16'($urandom);
            model_pixel(x, y, pixelData, mbusy);
            guard = 0;
            while (pixelReady !== 1'b1 && guard < 1000) begin
                guard++;
                @(negedge clock);
            end
            @(posedge clock);
            x++;
            if (x == 240) begin
                x = 0;
                y++;
            end
            @(negedge clock);
        end
        pixelWrite = 1'b0;
        guard = 0;
        while (pixelReady !== 1'b1 && guard < 1000) begin
            guard++;
            @(negedge clock);
        end
        check("raster drained", pixelReady, 1'b1);
        compare_stream("raster");

        got_q.delete();
        exp_q.delete();
        px = 0;
        py = 0;
        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 3);
            if (sel == 0 && px < 239) begin
                x = px + 1;
                y = py;
            end else if (sel == 1) begin
                x = $urandom_range(0, 1) ? $urandom_range(240, 255) : $urandom_range(0, 239);
                y = (x > 239) ? $urandom_range(0, 511) : $urandom_range(320, 511);
            end else begin
                x = $urandom_range(0, 239);
                y = $urandom_range(0, 319);
            end
            if (x <= 239 && y <= 319) begin
                px = x;
                py = y;
            end
            model_pixel(x, y, 16'($urandom), mbusy);
            send_pixel(x, y, exp_q.size() > 0 ? exp_q[exp_q.size()-1][15:0] : 16'h0, busy, s0, s1);
            check($sformatf("rand%0d busy clocks", i), busy, mbusy);
        end
        compare_stream("random");

        got_q.delete();
        exp_q.delete();
        @(negedge clock);
        xAddr = 8'd5;
        yAddr = 9'd300;
        pixelData = 16'hF800;
        pixelWrite = 1'b1;
        @(negedge clock);
        pixelWrite = 1'b0;
        guard = 0;
        while (got_q.size() < 6 && guard < 200) begin
            guard++;
            @(negedge clock);
        end
        check("reached word 6", got_q.size() >= 6, 1);
        @(posedge clock);
        #2 globalReset = 1'b1;
        #1;
        check_reset_values("mid-transfer reset");
        repeat (2) @(negedge clock);
        release_and_init("re-init");

        got_q.delete();
        exp_q.delete();
        model_pixel(5, 300, 16'hF800, mbusy);
        send_pixel(5, 300, 16'hF800, busy, s0, s1);
        check("post re-init busy", busy, FULL_BUSY);
        compare_stream("post re-init");

        check("Wr_n low pulse width", bad_width, 0);
        check("data/RS stable across word", bad_stable, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
